booth_mul_arbiter: RTL and testbench

//  - Shares one sequential radix-2 Booth multiplier core among NUM_REQ requesters.
//  - Uses round-robin arbitration with a valid/ready handshake per requester.
//  - Returns one tagged signed product at a time on a single response port.
//  - Sits between client engines and the multiplier datapath; it sequences load,

---
 rtl/booth_arb_pkg.sv | 22 ++
 rtl/booth_seq_core.sv | 80 ++++++++
 rtl/booth_mul_arbiter.sv | 132 +++++++++++++
 tb/tb_booth_mul_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_arb_pkg.sv
// booth_arb_pkg
//   Shared types and default sizes for the Booth multiplier arbiter.
//   state_t : arbiter FSM states (IDLE, RUN, RESP)
//   phase_t : Booth core iteration phase (ADDSUB, SHIFT)
//   DEF_WIDTH / DEF_NUM_REQ : default operand width and requester count
package booth_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        ADDSUB = 1'b0,
        SHIFT  = 1'b1
    } phase_t;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_NUM_REQ = 4;

endpackage

// File: rtl/booth_seq_core.sv
// booth_seq_core
//   Sequential radix-2 Booth multiplier. One add/sub phase and one shift
//   phase per multiplier bit, so a product takes 2*WIDTH cycles after start.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load a/b and begin a new multiplication
//   a, b       : signed multiplicand / multiplier, sampled on start
//   done       : high for one cycle once the product is complete
//   product    : signed 2*WIDTH-bit product {A,Q}, valid while done is high
module booth_seq_core
    import booth_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // The accumulator carries one guard bit above WIDTH. Subtracting a
    // multiplicand of -2^(WIDTH-1) from zero would otherwise flip the sign
    // seen by the following arithmetic shift, breaking (-2^(WIDTH-1))^2.
    logic signed [WIDTH:0] acc;
    logic signed [WIDTH:0] mcand;
    logic [WIDTH-1:0]      mplier;
    logic                  q_1;
    logic [CNT_W-1:0]      count;
    phase_t                phase;
    logic                  active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mplier <= '0;
            q_1    <= 1'b0;
            count  <= '0;
            phase  <= ADDSUB;
            active <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mplier <= b;
            q_1    <= 1'b0;
            count  <= CNT_W'(WIDTH);
            phase  <= ADDSUB;
            active <= 1'b1;
        end else if (active) begin
            if (count == '0) begin
                active <= 1'b0;
            end else if (phase == ADDSUB) begin
                case ({mplier[0], q_1})
                    2'b01:   acc <= acc + mcand;
                    2'b10:   acc <= acc - mcand;
                    default: ;
                endcase
                phase <= SHIFT;
            end else begin
                {acc, mplier, q_1} <= {acc[WIDTH], acc, mplier};
                count <= count - 1'b1;
                phase <= ADDSUB;
            end
        end
    end

    // Multiplicand only matters between start and done; no reset needed.
    always_ff @(posedge clk) begin
        if (start) begin
            mcand <= {a[WIDTH-1], a};
        end
    end

    assign done    = active && (count == '0);
    assign product = {acc[WIDTH-1:0], mplier};

endmodule

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter
//   Round-robin front end sharing one booth_seq_core among NUM_REQ requesters.
//   Flow: IDLE (grant + load) -> RUN (core iterates) -> RESP (hold result
//   until rsp_ready). Optional macro BOOTH_ARB_PERF_EN adds perf_ops, a
//   wrapping count of completed responses.
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester handshake (ready one-hot or zero)
//   req_a, req_b          : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready   : response handshake
//   rsp_id, rsp_product   : owner index and signed product
//   perf_ops              : completed response count (BOOTH_ARB_PERF_EN only)
//   busy                  : high whenever the FSM is not IDLE
module booth_mul_arbiter
    import booth_arb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]       rsp_product,
`ifdef BOOTH_ARB_PERF_EN
    output logic [31:0]              perf_ops,
`endif
    output logic                     busy
);

    state_t               state;
    state_t               state_nxt;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      grant_id;
    logic [ID_W-1:0]      cand;
    logic                 grant_found;
    logic [NUM_REQ-1:0]   grant_vec;
    logic                 core_start;
    logic                 core_done;
    logic [2*WIDTH-1:0]   core_product;
    logic [WIDTH-1:0]     sel_a;
    logic [WIDTH-1:0]     sel_b;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        grant_vec   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found     = 1'b1;
                grant_id        = cand;
                grant_vec[cand] = 1'b1;
            end
        end
    end

    assign sel_a      = req_a[grant_id*WIDTH +: WIDTH];
    assign sel_b      = req_b[grant_id*WIDTH +: WIDTH];
    assign core_start = (state == IDLE) && grant_found;

    booth_seq_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (core_start),
        .a       (sel_a),
        .b       (sel_b),
        .done    (core_done),
        .product (core_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_found) state_nxt = RUN;
            RUN:     if (core_done)   state_nxt = RESP;
            RESP:    if (rsp_ready)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE) ? grant_vec : '0;
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= ID_W'(NUM_REQ - 1);
            rsp_id      <= '0;
            rsp_product <= '0;
        end else begin
            if (core_start) begin
                rr_ptr <= grant_id;
                rsp_id <= grant_id;
            end
            if ((state == RUN) && core_done) begin
                rsp_product <= core_product;
            end
        end
    end

`ifdef BOOTH_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops <= '0;
        end else if (rsp_valid && rsp_ready) begin
            perf_ops <= perf_ops + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb_booth_mul_arbiter
//   Randomized and directed bench for booth_mul_arbiter. Expected grants come
//   from a round-robin pointer model and expected products from plain signed
//   multiplication of the operands the bench presented.
module tb_booth_mul_arbiter;

    localparam int WIDTH   = 16;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int LAT     = 2 * WIDTH + 1;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [2*WIDTH-1:0]       rsp_product;
    logic                     busy;
`ifdef BOOTH_ARB_PERF_EN
    logic [31:0]              perf_ops;
`endif

    logic [WIDTH-1:0] opa [NUM_REQ];
    logic [WIDTH-1:0] opb [NUM_REQ];

    int n_checks;
    int n_fails;
    int model_ptr;
    int perf_model;

    booth_mul_arbiter #(
        .WIDTH   (WIDTH),
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
`ifdef BOOTH_ARB_PERF_EN
        .perf_ops    (perf_ops),
`endif
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = opa[i];
            req_b[i*WIDTH +: WIDTH] = opb[i];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_grant(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'h0000;
            3:       return 16'hFFFF;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        model_ptr  = NUM_REQ - 1;
        perf_model = 0;
    endtask

    task automatic check_perf();
`ifdef BOOTH_ARB_PERF_EN
        chk("perf_ops", perf_ops, perf_model);
`endif
    endtask

    // One complete job: grant, latency, result, optional backpressure, handshake.
    task automatic serve_one(input int bp, output int gid, output logic [2*WIDTH-1:0] got_p);
        int w;
        int exp_idx;
        int lat;
        logic signed [2*WIDTH-1:0] sa;
        logic signed [2*WIDTH-1:0] sb;
        logic [2*WIDTH-1:0] want_p;
        logic [2*WIDTH-1:0] hold_p;
        logic [ID_W-1:0]    hold_id;
        gid   = -1;
        got_p = '0;
        #1;
        w = 0;
        while (req_ready == '0 && w < 50) begin
            step();
            w++;
        end
        if (req_ready == '0) begin
            chk("grant_timeout", 0, 1);
            return;
        end
        exp_idx = model_grant(req_valid, model_ptr);
        if (exp_idx < 0) exp_idx = 0;
        chk("grant", req_ready, 64'(1 << exp_idx));
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) gid = i;
        sa     = {{WIDTH{opa[exp_idx][WIDTH-1]}}, opa[exp_idx]};
        sb     = {{WIDTH{opb[exp_idx][WIDTH-1]}}, opb[exp_idx]};
        want_p = sa * sb;
        rsp_ready = (bp == 0);
        step();
        model_ptr = exp_idx;
        opa[exp_idx] = rnd_op();
        opb[exp_idx] = rnd_op();
        chk("busy_run", busy, 1);
        chk("ready_run", req_ready, 0);
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            step();
            lat++;
        end
        chk("latency", lat, LAT);
        chk("rsp_id", rsp_id, exp_idx);
        chk("rsp_product", rsp_product, want_p);
        got_p = rsp_product;
        if (bp > 0) begin
            hold_p  = rsp_product;
            hold_id = rsp_id;
            for (int k = 0; k < bp; k++) begin
                step();
                chk("bp_valid", rsp_valid, 1);
                chk("bp_product", rsp_product, hold_p);
                chk("bp_id", rsp_id, hold_id);
                chk("bp_ready", req_ready, 0);
            end
            rsp_ready = 1'b1;
        end
        step();
        perf_model++;
        chk("rsp_drop", rsp_valid, 0);
        chk("idle_busy", busy, 0);
    endtask

    typedef struct {
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [2*WIDTH-1:0] p;
    } dir_t;

    initial begin
        dir_t dir [4];
        int   order [10];
        int   g;
        int   cnt;
        logic [2*WIDTH-1:0] p;

        n_checks   = 0;
        n_fails    = 0;
        model_ptr  = NUM_REQ - 1;
        perf_model = 0;
        req_valid  = '0;
        rsp_ready  = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end

        rst_n = 1'b0;
        #12;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_product", rsp_product, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_busy", busy, 0);
        apply_reset();
        chk("idle_no_ready", req_ready, 0);
        check_perf();

        // Directed products from requester 0 alone.
        dir[0] = '{16'h0003, 16'hFFFB, 32'hFFFFFFF1};
        dir[1] = '{16'h8000, 16'h8000, 32'h40000000};
        dir[2] = '{16'h7FFF, 16'h8000, 32'hC0008000};
        dir[3] = '{16'h0000, 16'h1234, 32'h00000000};
        for (int i = 0; i < 4; i++) begin
            req_valid = 4'b0001;
            opa[0] = dir[i].a;
            opb[0] = dir[i].b;
            serve_one(0, g, p);
            req_valid = '0;
            chk("dir_id", g, 0);
            chk("dir_product", p, dir[i].p);
        end

        // Backpressure for 10 cycles on requester 1.
        req_valid = 4'b0010;
        opa[1] = 16'h1357;
        opb[1] = 16'hF00D;
        serve_one(10, g, p);
        req_valid = '0;
        chk("bp_gid", g, 1);
        check_perf();

        // Fairness from reset with all requesters active; req1 drops after its second grant.
        apply_reset();
        order = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2};
        for (int i = 0; i < NUM_REQ; i++) begin
            opa[i] = rnd_op();
            opb[i] = rnd_op();
        end
        req_valid = '1;
        for (int i = 0; i < 10; i++) begin
            serve_one(0, g, p);
            chk("fair_order", g, order[i]);
            if (i == 5) req_valid[1] = 1'b0;
        end
        req_valid = '0;
        check_perf();

        // Random masks, operands and backpressure.
        for (int i = 0; i < 20; i++) begin
            req_valid = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            serve_one($urandom_range(0, 3), g, p);
        end
        req_valid = '0;
        check_perf();

        // Reset in the middle of a run abandons the job.
        req_valid = 4'b0100;
        opa[2] = 16'h4321;
        opb[2] = 16'h8765;
        #1;
        chk("mid_grant", req_ready, 4'b0100);
        step();
        req_valid = '0;
        for (int k = 0; k < 5; k++) step();
        chk("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_product", rsp_product, 0);
        chk("mid_rst_id", rsp_id, 0);
        chk("mid_rst_busy", busy, 0);
        step();
        rst_n = 1'b1;
        model_ptr  = NUM_REQ - 1;
        perf_model = 0;
        cnt = 0;
        for (int k = 0; k < 3 * LAT; k++) begin
            step();
            if (rsp_valid) cnt++;
        end
        chk("mid_no_response", cnt, 0);
        check_perf();
        req_valid = '1;
        serve_one(0, g, p);
        req_valid = '0;
        chk("post_rst_grant", g, 0);
        check_perf();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
